io_hex_controller: RTL and testbench
====================================

Name: io_hex_controller

Overview:
Parametrised successor to the processor's IO unit. Serves the IN instruction with a debounced, handshaked switch read. Serves the OUT instruction by converting a binary word to decimal with a sequential double-dabble engine and driving DIGITS seven-segment displays. It sits between the core (in_req/out_req/stall) and the board pins (SW, insert, HEX).

Parameters:
DATA_W, 32, width of out_data and user_input
SW_W, 18, number of switch inputs (SW_W <= DATA_W)
DIGITS, 8, number of seven-segment digits
DEBOUNCE_CYC, 4, consecutive stable cycles required on insert

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
insert  in  1  raw push-button, asynchronous to CLK
SW  in  SW_W  switch value
in_req  in  1  core is executing IN (level)
out_req  in  1  core is executing OUT (level)
out_data  in  DATA_W  word to display
halt  in  1  core halted
user_input  out  DATA_W  latched switch value
in_ready  out  1  one-cycle pulse: IN completed
stall  out  1  core must hold PC
busy  out  1  converter active
ovf  out  1  last displayed value did not fit
hex  out  7*DIGITS  active-low segments; digit i at [7i+6:7i], bit0=a … bit6=g

Behaviour:
- Reset (reset=0, async): user_input=0, in_ready=0, stall=0, busy=0, ovf=0; digit0 shows "0" (7'b1000000), all other digits blank (7'h7F); input FSM=IN_IDLE; debounce state cleared.
- Insert conditioning: 2-flop synchroniser, then a counter. The debounced level changes only after DEBOUNCE_CYC consecutive equal samples. ins_evt is a single-cycle pulse on the debounced rising edge. Holding the button produces one event only.
- Input FSM, states IN_IDLE, IN_WAIT, IN_DONE:
  - IN_IDLE: in_req=1 and halt=0 → IN_WAIT.
  - IN_WAIT: ins_evt → user_input <= zero-extended SW, go to IN_DONE. in_req dropping → IN_IDLE.
  - IN_DONE: in_ready=1 for this cycle only, then → IN_IDLE unconditionally.
  - ins_evt outside IN_WAIT is discarded.
- Converter:
  - Accept: at a rising edge where out_req=1, busy=0 and halt=0. Latch out_data and clear the BCD register (4*DIGITS bits).
  - Shift: busy=1 for exactly DATA_W cycles after the accept edge. Each cycle, add 3 to every BCD nibble >=5, then shift one bit MSB-first.
  - ovf: set sticky for this conversion when a 1 is shifted out of the BCD MSB.
  - Display update: on the edge ending the last shift cycle, busy falls and hex/ovf update together. Digits show only at these updates.
  - Re-accept: one out_req level accepts once. A new accept requires out_req to have been low for at least one cycle. This allows back-to-back OUT instructions separated by one cycle.
- Display formatting:
  - Leading-zero blanking: digits above the most significant non-zero digit are blank. A value of 0 shows a single "0".
  - ovf=1: every digit shows a dash (7'b0111111).
- stall = (in_req & state!=IN_DONE & !halt) | (out_req & busy & !halt). stall is combinational from in_req/out_req. It is never asserted while halt=1.
- halt=1: input FSM forced to IN_IDLE next edge. No new conversion is accepted. A running conversion completes. Display holds.
- Reset mid-operation: conversion aborted, display returns to the reset pattern.
- Simultaneous in_req and out_req are not produced by the core. If they occur, both paths operate independently.

Optional Feature:
SIGNED_DISPLAY_EN:
- Defined: out_data is two's complement. A negative value converts its magnitude, with -2^(DATA_W-1) handled as unsigned 2^(DATA_W-1). A '-' (7'b0111111) is placed in the digit immediately left of the most significant digit. If the magnitude occupies all DIGITS, ovf=1 and all digits show dashes.
- Undefined: out_data is unsigned and no sign logic is synthesised.

Test Plan:
1. Assert reset low in the 10th cycle of a conversion of 12345678 → busy=0, ovf=0, hex shows digit0 "0" with the rest blank, user_input=0, stall=0.
2. in_req=1, SW=18'h2A5F5, insert high for 10 cycles after 20 idle cycles (DEBOUNCE_CYC=4) → stall=1 until IN_DONE; user_input=32'h0002A5F5; in_ready high exactly 1 cycle; holding insert gives no second event.
3. insert glitches of 1–3 cycles while in IN_WAIT → no ins_evt, stall stays 1, user_input unchanged.
4. out_req pulse, out_data=1234 → busy high 32 cycles; then digits0..3 show 4,3,2,1 and digits4..7 are blank. out_data=0 → only digit0 "0".
5. out_data=100000000 (DIGITS=8) → ovf=1, all dashes. Next out_data=99999999 → ovf=0, eight 9s.
6. out_req held during busy → stall=1 until accept, then the second value is displayed. With SIGNED_DISPLAY_EN, out_data=32'hFFFFFFFB → digit0 "5", digit1 '-', rest blank.

Source files
------------

// File: rtl/io_hex_controller.sv
// io_hex_controller
//   IO unit between the core and the board pins.
//   IN : debounced push-button read of the switches with an in_ready handshake.
//   OUT: sequential double-dabble conversion of out_data to decimal, shown on
//        DIGITS active-low seven-segment displays (bit0=a .. bit6=g).
//
// Ports
//   CLK        system clock, rising edge
//   reset      asynchronous active-low reset
//   insert     raw push-button (asynchronous to CLK)
//   SW         switch value, zero-extended into user_input
//   in_req     core executing IN (level)
//   out_req    core executing OUT (level)
//   out_data   word to display
//   halt       core halted: no new IN/OUT activity is started
//   user_input latched switch value
//   in_ready   one-cycle pulse when an IN completes
//   stall      core must hold its PC (combinational)
//   busy       converter active
//   ovf        last displayed value did not fit
//   hex        digit i at hex[7i+6:7i]
//
// Build option
//   SIGNED_DISPLAY_EN : treat out_data as two's complement and show a leading
//                       '-' for negative values. Undefined: unsigned only.
//
// Input FSM
//   state   | meaning
//   IN_IDLE | no IN in progress
//   IN_WAIT | IN issued, waiting for a debounced insert press
//   IN_DONE | switches latched, in_ready high for this cycle
module io_hex_controller #(
  parameter int DATA_W       = 32,
  parameter int SW_W         = 18,
  parameter int DIGITS       = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  insert,
  input  logic [SW_W-1:0]       SW,
  input  logic                  in_req,
  input  logic                  out_req,
  input  logic [DATA_W-1:0]     out_data,
  input  logic                  halt,
  output logic [DATA_W-1:0]     user_input,
  output logic                  in_ready,
  output logic                  stall,
  output logic                  busy,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [DB_W-1:0]  DB_LOAD  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SH_LOAD  = CNT_W'(DATA_W - 1);
  localparam logic [6:0]       SEG_BLK  = 7'h7F;
  localparam logic [6:0]       SEG_DASH = 7'b0111111;
  localparam logic [7*DIGITS-1:0] HEX_RST = {{(DIGITS-1){7'h7F}}, 7'b1000000};

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLK;
    endcase
  endfunction

  // Leading-zero blanking; digit 0 is always shown so a zero value reads "0".
  function automatic logic [7*DIGITS-1:0] fmt_hex(input logic [BCD_W-1:0] bcd,
                                                  input logic neg,
                                                  input logic all_dash);
    int msd;
    msd = 0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    for (int i = 0; i < DIGITS; i++) begin
      if (all_dash)                 fmt_hex[7*i +: 7] = SEG_DASH;
      else if (i <= msd)            fmt_hex[7*i +: 7] = seg7(bcd[4*i +: 4]);
      else if (neg && i == msd + 1) fmt_hex[7*i +: 7] = SEG_DASH;
      else                          fmt_hex[7*i +: 7] = SEG_BLK;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Insert conditioning: synchroniser, then a down-counter that must reach
  // terminal count on consecutive differing samples before the level flips.
  // ---------------------------------------------------------------------------
  logic            sync1_q, sync2_q, deb_q, ins_evt_q;
  logic [DB_W-1:0] db_cnt_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      ins_evt_q <= 1'b0;
      db_cnt_q  <= DB_LOAD;
    end else begin
      sync1_q   <= insert;
      sync2_q   <= sync1_q;
      ins_evt_q <= 1'b0;
      if (sync2_q == deb_q) begin
        db_cnt_q <= DB_LOAD;
      end else if (db_cnt_q == '0) begin
        deb_q     <= sync2_q;
        ins_evt_q <= sync2_q;
        db_cnt_q  <= DB_LOAD;
      end else begin
        db_cnt_q <= db_cnt_q - DB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Input FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {IN_IDLE, IN_WAIT, IN_DONE} in_state_e;

  in_state_e         in_state_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] user_input_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      in_state_q   <= IN_IDLE;
      in_ready_q   <= 1'b0;
      user_input_q <= '0;
    end else begin
      in_ready_q <= 1'b0;
      if (halt) begin
        in_state_q <= IN_IDLE;
      end else begin
        case (in_state_q)
          IN_IDLE: if (in_req) in_state_q <= IN_WAIT;
          IN_WAIT: begin
            if (ins_evt_q) begin
              user_input_q <= DATA_W'(SW);
              in_ready_q   <= 1'b1;
              in_state_q   <= IN_DONE;
            end else if (!in_req) begin
              in_state_q <= IN_IDLE;
            end
          end
          IN_DONE: in_state_q <= IN_IDLE;
          default: in_state_q <= IN_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Converter
  // ---------------------------------------------------------------------------
  logic                 busy_q, armed_q, ovf_run_q, ovf_q;
  logic [DATA_W-1:0]    bin_q, mag;
  logic [BCD_W-1:0]     bcd_q, bcd_adj, bcd_d;
  logic [CNT_W-1:0]     sh_cnt_q;
  logic [7*DIGITS-1:0]  hex_q, hex_d;
  logic                 accept, carry, sign_ovf, disp_neg, ovf_d;

`ifdef SIGNED_DISPLAY_EN
  logic neg_q;
  // Negating the most negative value wraps to itself, which read as unsigned
  // is exactly its magnitude.
  assign mag      = out_data[DATA_W-1] ? (~out_data + DATA_W'(1)) : out_data;
  assign disp_neg = neg_q;
  // A sign needs a free digit to the left of the most significant digit.
  assign sign_ovf = neg_q & (bcd_d[BCD_W-1 -: 4] != 4'd0);
`else
  assign mag      = out_data;
  assign disp_neg = 1'b0;
  assign sign_ovf = 1'b0;
`endif

  // armed_q remembers that out_req has been low since the last accept.
  assign accept = out_req & ~busy_q & ~halt & armed_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  assign carry = bcd_adj[BCD_W-1];
  assign bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
  assign ovf_d = ovf_run_q | carry | sign_ovf;
  assign hex_d = fmt_hex(bcd_d, disp_neg, ovf_d);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      armed_q   <= 1'b1;
      ovf_run_q <= 1'b0;
      ovf_q     <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      sh_cnt_q  <= '0;
      hex_q     <= HEX_RST;
`ifdef SIGNED_DISPLAY_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      if (!out_req) armed_q <= 1'b1;
      if (accept) begin
        busy_q    <= 1'b1;
        armed_q   <= 1'b0;
        bin_q     <= mag;
        bcd_q     <= '0;
        ovf_run_q <= 1'b0;
        sh_cnt_q  <= SH_LOAD;
`ifdef SIGNED_DISPLAY_EN
        neg_q     <= out_data[DATA_W-1];
`endif
      end else if (busy_q) begin
        bin_q     <= bin_q << 1;
        bcd_q     <= bcd_d;
        ovf_run_q <= ovf_run_q | carry;
        sh_cnt_q  <= sh_cnt_q - CNT_W'(1);
        if (sh_cnt_q == '0) begin
          busy_q <= 1'b0;
          hex_q  <= hex_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end

  assign stall      = ~halt & ((in_req & (in_state_q != IN_DONE)) | (out_req & busy_q));
  assign busy       = busy_q;
  assign ovf        = ovf_q;
  assign hex        = hex_q;
  assign in_ready   = in_ready_q;
  assign user_input = user_input_q;

endmodule

// File: tb/tb_io_hex_controller.sv
module tb_io_hex_controller;
  localparam int DATA_W = 32, SW_W = 18, DIGITS = 8, DEBOUNCE_CYC = 4;
  localparam logic [55:0] HEX_RST = {{7{7'h7F}}, 7'b1000000};

  logic              CLK = 1'b0, reset = 1'b0, insert = 1'b0;
  logic              in_req = 1'b0, out_req = 1'b0, halt = 1'b0;
  logic [SW_W-1:0]   SW = '0;
  logic [DATA_W-1:0] out_data = '0;
  logic [DATA_W-1:0] user_input;
  logic              in_ready, stall, busy, ovf;
  logic [7*DIGITS-1:0] hex;

  io_hex_controller #(.DATA_W(DATA_W), .SW_W(SW_W), .DIGITS(DIGITS),
                      .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
    .CLK(CLK), .reset(reset), .insert(insert), .SW(SW), .in_req(in_req),
    .out_req(out_req), .out_data(out_data), .halt(halt),
    .user_input(user_input), .in_ready(in_ready), .stall(stall),
    .busy(busy), .ovf(ovf), .hex(hex));

  always #5 CLK = ~CLK;

  int n_checks = 0, n_pass = 0;
  logic [31:0] exp_ui = '0;
  logic [55:0] exp_hex = HEX_RST;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  function automatic logic [6:0] seg_of(input longint d);
    case (d)
      0: seg_of = 7'h40; 1: seg_of = 7'h79; 2: seg_of = 7'h24; 3: seg_of = 7'h30;
      4: seg_of = 7'h19; 5: seg_of = 7'h12; 6: seg_of = 7'h02; 7: seg_of = 7'h78;
      8: seg_of = 7'h00; default: seg_of = 7'h10;
    endcase
  endfunction

  // Decimal rendering of a value, straight from arithmetic on the number.
  task automatic model_display(input logic [31:0] v, output logic [55:0] hx, output logic ov);
    longint mag, lim, t;
    bit neg;
    int ndig;
    neg = 1'b0;
    mag = longint'(v);
`ifdef SIGNED_DISPLAY_EN
    if (v[31]) begin
      neg = 1'b1;
      mag = 64'h1_0000_0000 - longint'(v);
    end
`endif
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    ov = (mag >= lim);
    ndig = 1;
    t = mag;
    while (t >= 10) begin t = t / 10; ndig++; end
    if (neg && ndig >= DIGITS) ov = 1'b1;
    t = mag;
    for (int i = 0; i < DIGITS; i++) begin
      if (ov)                      hx[7*i +: 7] = 7'b0111111;
      else if (i < ndig)           hx[7*i +: 7] = seg_of(t % 10);
      else if (neg && i == ndig)   hx[7*i +: 7] = 7'b0111111;
      else                         hx[7*i +: 7] = 7'h7F;
      t = t / 10;
    end
  endtask

  // Count busy cycles after the accept edge (caller sits just after that edge).
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; tick(); end
  endtask

  task automatic run_out(input logic [31:0] v, input string tag);
    logic [55:0] eh;
    logic eo;
    int n;
    out_data = v;
    out_req  = 1'b1;
    @(negedge CLK);
    check({tag, "_stall_idle"}, 64'(stall), 64'(0));
    tick();
    out_req = 1'b0;
    count_busy(n);
    model_display(v, eh, eo);
    exp_hex = eh;
    check({tag, "_busy_cycles"}, 64'(n), 64'(32));
    check({tag, "_hex"}, 64'(hex), 64'(eh));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  task automatic run_in(input logic [SW_W-1:0] sw, input int hold, input string tag);
    int rdy;
    in_req = 1'b1;
    SW     = sw;
    @(negedge CLK);
    check({tag, "_stall_wait"}, 64'(stall), 64'(1));
    repeat (20) tick();
    @(negedge CLK);
    check({tag, "_stall_idle20"}, 64'(stall), 64'(1));
    tick();
    insert = 1'b1;
    rdy = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (c == hold) insert = 1'b0;
      @(negedge CLK);
      if (in_ready === 1'b1) begin
        rdy++;
        if (rdy == 1) check({tag, "_stall_done"}, 64'(stall), 64'(0));
      end
    end
    exp_ui = 32'(sw);
    check({tag, "_ready_cycles"}, 64'(rdy), 64'(1));
    check({tag, "_user_input"}, 64'(user_input), 64'(exp_ui));
    check({tag, "_stall_rewait"}, 64'(stall), 64'(1));
    in_req = 1'b0;
    @(negedge CLK);
    check({tag, "_stall_dropped"}, 64'(stall), 64'(0));
    repeat (12) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, rdy, bad;
    logic [55:0] eh;
    logic eo;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_hex", 64'(hex), 64'(HEX_RST));
    check("rst_user_input", 64'(user_input), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // IN with held button
    run_in(18'h2A5F5, 10, "in_main");

    // Glitches on insert while waiting
    in_req = 1'b1;
    SW = 18'h155AA;
    for (int w = 1; w <= 3; w++) begin
      rdy = 0;
      tick();
      insert = 1'b1;
      repeat (w) tick();
      insert = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge CLK);
        if (in_ready === 1'b1) rdy++;
        tick();
      end
      check($sformatf("glitch%0d_ready", w), 64'(rdy), 64'(0));
      check($sformatf("glitch%0d_stall", w), 64'(stall), 64'(1));
      check($sformatf("glitch%0d_ui", w), 64'(user_input), 64'(exp_ui));
    end
    in_req = 1'b0;
    repeat (3) tick();

    // Directed conversions
    run_out(32'd1234, "out_1234");
    run_out(32'd0, "out_zero");
    run_out(32'd100000000, "out_1e8");
    run_out(32'd99999999, "out_max8");
    run_out(32'hFFFFFFFF, "out_allones");
    run_out(32'd10000000, "out_1e7");
    run_out(32'd9999999, "out_max7");
    run_out(32'd7, "out_7");
`ifdef SIGNED_DISPLAY_EN
    run_out(32'hFFFFFFFB, "out_neg5");
    run_out(32'h80000000, "out_minint");
    run_out(-32'sd9999999, "out_neg_max7");
    run_out(-32'sd1234, "out_neg1234");
`endif

    // Randomised conversions
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0: run_out($urandom, $sformatf("rnd%0d", k));
        1: run_out($urandom_range(0, 99999999), $sformatf("rnd%0d", k));
        2: run_out($urandom_range(0, 999), $sformatf("rnd%0d", k));
        default: run_out($urandom_range(90000000, 110000000), $sformatf("rnd%0d", k));
      endcase
    end

    // out_req held while busy: stall until accept, then second value shown
    out_data = 32'd4321;
    out_req = 1'b1;
    tick();
    out_req = 1'b0;
    tick();
    out_data = 32'd56789;
    out_req = 1'b1;
    n = 0;
    bad = 0;
    @(negedge CLK);
    while (busy === 1'b1 && n < 200) begin
      if (stall !== 1'b1) bad++;
      n++;
      @(negedge CLK);
    end
    check("held_busy_samples", 64'(n), 64'(31));
    check("held_stall_low_cnt", 64'(bad), 64'(0));
    check("held_stall_free", 64'(stall), 64'(0));
    model_display(32'd4321, eh, eo);
    check("held_first_hex", 64'(hex), 64'(eh));
    tick();
    out_req = 1'b0;
    count_busy(n);
    model_display(32'd56789, eh, eo);
    exp_hex = eh;
    check("held_second_busy", 64'(n), 64'(32));
    check("held_second_hex", 64'(hex), 64'(eh));

    // One out_req level accepts only once
    out_data = 32'd2468;
    out_req = 1'b1;
    tick();
    count_busy(n);
    check("level_busy", 64'(n), 64'(32));
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (busy !== 1'b0) bad++;
      tick();
    end
    check("level_no_reaccept", 64'(bad), 64'(0));
    model_display(32'd2468, eh, eo);
    exp_hex = eh;
    check("level_hex", 64'(hex), 64'(eh));
    out_req = 1'b0;
    tick();

    // halt: no accept, no stall, display holds
    halt = 1'b1;
    out_data = 32'd111;
    out_req = 1'b1;
    in_req = 1'b1;
    @(negedge CLK);
    check("halt_stall", 64'(stall), 64'(0));
    repeat (5) tick();
    check("halt_busy", 64'(busy), 64'(0));
    check("halt_hex_hold", 64'(hex), 64'(exp_hex));
    out_req = 1'b0;
    in_req = 1'b0;
    tick();
    halt = 1'b0;
    tick();

    // halt raised mid-conversion: the conversion still completes
    out_data = 32'd8675309;
    out_req = 1'b1;
    tick();
    out_req = 1'b0;
    halt = 1'b1;
    count_busy(n);
    model_display(32'd8675309, eh, eo);
    check("halt_run_busy", 64'(n), 64'(32));
    check("halt_run_hex", 64'(hex), 64'(eh));
    halt = 1'b0;
    tick();

    // Randomised IN reads
    for (int k = 0; k < 3; k++)
      run_in(SW_W'($urandom), $urandom_range(8, 16), $sformatf("in_rnd%0d", k));

    // Reset in the 10th cycle of a conversion
    out_data = 32'd12345678;
    out_req = 1'b1;
    tick();
    out_req = 1'b0;
    repeat (8) tick();
    check("pre_rst_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_ovf", 64'(ovf), 64'(0));
    check("midrst_hex", 64'(hex), 64'(HEX_RST));
    check("midrst_user_input", 64'(user_input), 64'(0));
    check("midrst_stall", 64'(stall), 64'(0));
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("postrst_hex", 64'(hex), 64'(HEX_RST));
    run_out(32'd5, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
